uart_bus_master: RTL and testbench
==================================

# uart_bus_master

Host-side bus initiator for the UART peripheral's CPU interface. It turns single-register read and write commands from a local requester into correctly sequenced NCS/NO/NW/ADDR/DATA bus cycles. It also watches NINT and, when enabled, services interrupts on its own: it reads the status register and drains received bytes. It sits between the controlling logic (test harness or soft CPU) and the peripheral's bus pins.

## Interface
Parameters:
- WAIT_CYCLES, 2: strobe (NO/NW) low duration in cycles; legal range 1–15.

Ports:
- CLK  in  1: system clock; everything is rising-edge.
- RST  in  1: asynchronous, active-high reset.
- cmd_valid  in  1: command request.
- cmd_ready  out  1: command accepted on an edge where cmd_valid & cmd_ready.
- cmd_write  in  1: 1 = write, 0 = read.
- cmd_addr  in  2: register address (0 status, 1 interrupt mask, 2 data, 3 baud).
- cmd_wdata  in  8: write data.
- rsp_valid  out  1: one-cycle pulse when a host read completes.
- rsp_rdata  out  8: read data; valid while rsp_valid.
- irq_en  in  1: enables automatic interrupt servicing.
- rx_valid  out  1: one-cycle pulse when the interrupt service reads a data byte.
- rx_data  out  8: byte read from register 2; valid while rx_valid.
- NCS  out  1: negative chip select.
- NO  out  1: negative read enable.
- NW  out  1: negative write enable.
- ADDR  out  2: register address on the bus.
- DATA  inout  8: bidirectional data bus.
- NINT  in  1: negative interrupt from the peripheral; asynchronous.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. A service sub-sequencer (S_NONE, S_STAT, S_DATA) selects what the next access is.
- Access sequence:
  - SETUP (1 cycle): NCS=0, ADDR valid, strobes high.
  - STROBE (WAIT_CYCLES cycles): NO=0 for a read, NW=0 for a write.
  - HOLD (1 cycle): strobes high; NCS and ADDR unchanged.
  - Then IDLE with NCS=1.
- ADDR is stable from SETUP through HOLD.
- DATA is driven with the write data from SETUP through HOLD on writes only. It is high-Z at all other times, including the whole of every read.
- Read data is captured on the edge that ends the last STROBE cycle.
- NINT passes through a 2-flop synchronizer; nint_s is the active-high synchronized request.
- Arbitration in IDLE:
  - If irq_en & nint_s, start a service read of address 0 (S_STAT). cmd_ready=0 in that cycle.
  - Otherwise cmd_ready=1, and an accepted command starts SETUP on the next cycle.
- Service sequence:
  - S_STAT read completes with status bit 1 (receive data available) set: the next access is a read of address 2 (S_DATA).
  - S_STAT read completes with bit 1 clear: return to S_NONE.
  - S_DATA completes: pulse rx_valid with the byte, then return to S_NONE.
  - A service sequence is never interrupted by host commands.
- Command inputs are sampled only at acceptance; later changes have no effect.
- Host writes produce no response pulse.
- Service reads never assert rsp_valid. Host reads never assert rx_valid.
- Clearing irq_en mid-service: the current sequence still finishes; no new sequence starts.

## Timing
- Reset values:
  - Bus strobes: NCS=NO=NW=1, ADDR=0, DATA=Z.
  - Handshake/response: cmd_ready=0 while RST is high, rsp_valid=0, rsp_rdata=0.
  - Service outputs: rx_valid=0, rx_data=0.
  - Internal: FSM in IDLE, service state S_NONE, synchronizer flops cleared (nint_s=0).
- RST asserted mid-access: bus is released immediately (asynchronous). The aborted access produces no response.
- Access length is 2+WAIT_CYCLES cycles, from acceptance edge to first IDLE cycle.
- rsp_valid or rx_valid is high in the first IDLE cycle after HOLD. cmd_ready may also be high in that cycle.
- NCS is high for at least 1 cycle between any two accesses.
- NINT-to-service latency: NINT fall to service SETUP is at most 3 cycles plus the remainder of any access in progress.
- A level NINT still low after a service sequence re-triggers service, so a FIFO-style receiver is drained byte by byte.

## Test plan
- Write (W=2): cmd write addr 3, data 0x0C.
  - SETUP: NCS=0, ADDR=3, DATA=0x0C.
  - Next 2 cycles: NW=0.
  - HOLD: NW=1, NCS=0.
  - Then NCS=1, DATA=Z, no rsp_valid.
- Read (W=2): cmd read addr 1; bench drives DATA=0xA5 while NO=0.
  - Required: NO low for exactly 2 cycles, DATA never driven by the DUT.
  - rsp_valid for 1 cycle with rsp_rdata=0xA5, 4 cycles after acceptance.
- Interrupt: irq_en=1, NINT=0, bench returns status 0x02 then data 0x41.
  - Required: read addr 0, then read addr 2.
  - rx_valid pulse with rx_data=0x41; rsp_valid stays 0; cmd_ready=0 throughout.
- Interrupt with empty status (0x00):
  - Exactly one read, of addr 0, and no rx_valid.
  - Re-service begins once nint_s is still high in IDLE.
- Simultaneous cmd_valid and nint_s in IDLE:
  - Service runs first; the command is accepted only after service completes.
  - Back-to-back host commands show NCS high for 1 cycle between them.
- RST pulse during STROBE of a write:
  - NW, NCS high and DATA=Z in the same cycle RST rises; FSM in IDLE after release.
  - A following read completes normally.

Source files
------------

// File: rtl/uart_bus_master_if.sv
// Command/response handshake between a requester and uart_bus_master.
// The requester holds the master modport; the bus master is the slave.
interface uart_bus_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_write;
  logic [1:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;

  modport master (
    output cmd_valid,
    output cmd_write,
    output cmd_addr,
    output cmd_wdata,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_rdata
  );

  modport slave (
    input  cmd_valid,
    input  cmd_write,
    input  cmd_addr,
    input  cmd_wdata,
    output cmd_ready,
    output rsp_valid,
    output rsp_rdata
  );
endinterface

// File: rtl/uart_bus_master.sv
// Bus initiator for the UART CPU port: sequences host register accesses
// and autonomously services NINT by reading status and draining RX data.
module uart_bus_master #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  uart_bus_master_if.slave cmd,
  input  logic             irq_en,
  output logic             rx_valid,
  output logic [7:0]       rx_data,
  output logic             NCS,
  output logic             NO,
  output logic             NW,
  output logic [1:0]       ADDR,
  inout  wire  [7:0]       DATA,
  input  logic             NINT
);

  typedef enum logic [1:0] {
    IDLE, SETUP, STROBE, HOLD
  } state_t;

  typedef enum logic [1:0] {
    S_NONE, S_STAT, S_DATA
  } svc_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  state_t     state, state_d;
  svc_t       svc, svc_d;
  logic [3:0] wcnt, wcnt_d;
  logic [1:0] nint_sync;
  logic       nint_s;
  logic       wr_q;
  logic [1:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rd_q;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;

  logic       load, ready, cap, done;
  logic       ld_write;
  logic [1:0] ld_addr;
  logic [7:0] ld_wdata;
  logic       host_done, svc_done;

  assign nint_s = nint_sync[1];

  always_comb begin
    state_d  = state;
    svc_d    = svc;
    wcnt_d   = wcnt;
    load     = 1'b0;
    ready    = 1'b0;
    cap      = 1'b0;
    done     = 1'b0;
    ld_write = 1'b0;
    ld_addr  = addr_q;
    ld_wdata = wdata_q;
    unique case (state)
      IDLE: begin
        // A pending data read finishes the service before anything else.
        if (svc == S_DATA) begin
          load    = 1'b1;
          ld_addr = 2'd2;
        end else if (irq_en && nint_s) begin
          load    = 1'b1;
          ld_addr = 2'd0;
          svc_d   = S_STAT;
        end else begin
          ready = 1'b1;
          if (cmd.cmd_valid) begin
            load     = 1'b1;
            ld_write = cmd.cmd_write;
            ld_addr  = cmd.cmd_addr;
            ld_wdata = cmd.cmd_wdata;
          end
        end
        if (load) state_d = SETUP;
      end
      SETUP: begin
        state_d = STROBE;
        wcnt_d  = WLAST;
      end
      STROBE: begin
        if (wcnt == 4'd0) begin
          state_d = HOLD;
          cap     = 1'b1;
        end else begin
          wcnt_d = wcnt - 4'd1;
        end
      end
      HOLD: begin
        state_d = IDLE;
        done    = 1'b1;
        if (svc == S_STAT) begin
          svc_d = rd_q[1] ? S_DATA : S_NONE;
        end else if (svc == S_DATA) begin
          svc_d = S_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign host_done = done && (svc == S_NONE) && !wr_q;
  assign svc_done  = done && (svc == S_DATA);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      nint_sync   <= 2'b00;
      state       <= IDLE;
      svc         <= S_NONE;
      wcnt        <= 4'd0;
      wr_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 8'h00;
      rd_q        <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rx_valid    <= 1'b0;
      rx_data     <= 8'h00;
    end else begin
      nint_sync   <= {nint_sync[0], ~NINT};
      state       <= state_d;
      svc         <= svc_d;
      wcnt        <= wcnt_d;
      rsp_valid_q <= host_done;
      rx_valid    <= svc_done;
      if (load) begin
        wr_q    <= ld_write;
        addr_q  <= ld_addr;
        wdata_q <= ld_wdata;
      end
      if (cap)       rd_q        <= DATA;
      if (host_done) rsp_rdata_q <= rd_q;
      if (svc_done)  rx_data     <= rd_q;
    end
  end

  assign cmd.cmd_ready = ready && !RST;
  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_rdata = rsp_rdata_q;

  assign NCS  = (state == IDLE);
  assign NO   = !((state == STROBE) && !wr_q);
  assign NW   = !((state == STROBE) && wr_q);
  assign ADDR = addr_q;
  assign DATA = ((state != IDLE) && wr_q) ? wdata_q : 8'hzz;

endmodule

// File: tb/tb_uart_bus_master.sv
// Directed bench for uart_bus_master: host command table, interrupt
// service, arbitration, back-to-back accesses and mid-access reset.
module tb_uart_bus_master;
  localparam int W = 2;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       irq_en = 1'b0;
  logic       NINT = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       NCS, NO, NW;
  logic [1:0] ADDR;
  wire  [7:0] DATA;
  logic [7:0] preg [4];

  uart_bus_master_if bif();

  uart_bus_master #(.WAIT_CYCLES(W)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .cmd     (bif),
    .irq_en  (irq_en),
    .rx_valid(rx_valid),
    .rx_data (rx_data),
    .NCS     (NCS),
    .NO      (NO),
    .NW      (NW),
    .ADDR    (ADDR),
    .DATA    (DATA),
    .NINT    (NINT)
  );

  // Peripheral model: returns its register only while NO is low.
  assign DATA = (NO == 1'b0) ? preg[ADDR] : 8'hzz;

  always #5 CLK = ~CLK;

  typedef struct {
    bit         w;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
    bit         rsp;
  } vec_t;

  typedef struct {
    bit         w;
    logic [1:0] addr;
    logic [7:0] sdata;
    bit         sz;
    int         ncyc;
    int         nolow;
    int         nwlow;
    int         gap;
    bit         ok;
  } acc_t;

  vec_t vecs [6];
  acc_t acc_q [$];
  acc_t cur;
  bit   in_acc = 1'b0;
  int   idle_cnt = 100;

  int checks = 0;
  int errors = 0;
  int rsp_n, rsp_at, rx_n, rdy_n, lat, n;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int k = 0;
    while (bif.cmd_ready !== 1'b1 && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk({nm, " accepted"}, 32'(bif.cmd_ready), 1);
  endtask

  task automatic wait_ncs(input logic lvl, input string nm);
    int k = 0;
    while (NCS !== lvl && k < 60) begin
      @(negedge CLK);
      k++;
    end
    chk({nm, " ncs"}, 32'(NCS), 32'(lvl));
  endtask

  // Bus monitor: one record per NCS-low window.
  always @(negedge CLK) begin
    if (RST) begin
      in_acc   = 1'b0;
      idle_cnt = 100;
    end else if (NCS === 1'b0) begin
      if (!in_acc) begin
        in_acc    = 1'b1;
        cur.addr  = ADDR;
        cur.sdata = DATA;
        cur.sz    = (DATA === 8'hzz);
        cur.ncyc  = 0;
        cur.nolow = 0;
        cur.nwlow = 0;
        cur.gap   = idle_cnt;
        cur.ok    = 1'b1;
        cur.w     = 1'b0;
      end
      cur.ncyc++;
      if (NO === 1'b0) begin
        cur.nolow++;
        if (DATA !== preg[ADDR]) cur.ok = 1'b0;
      end else if (cur.sz ? (DATA !== 8'hzz) : (DATA !== cur.sdata)) begin
        cur.ok = 1'b0;
      end
      if (NW === 1'b0) begin
        cur.nwlow++;
        cur.w = 1'b1;
      end
      if (ADDR !== cur.addr) cur.ok = 1'b0;
      if (NO === 1'b0 && NW === 1'b0) cur.ok = 1'b0;
    end else begin
      if (in_acc) begin
        in_acc = 1'b0;
        if (DATA !== 8'hzz) cur.ok = 1'b0;
        acc_q.push_back(cur);
        idle_cnt = 0;
      end
      idle_cnt++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bif.cmd_valid = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 2'd0;
    bif.cmd_wdata = 8'h00;
    for (int i = 0; i < 4; i++) preg[i] = 8'h00;

    vecs[0] = '{1'b1, 2'd3, 8'h0C, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 2'd1, 8'h00, 8'hA5, 1'b1};
    vecs[2] = '{1'b1, 2'd1, 8'h5E, 8'h00, 1'b0};
    vecs[3] = '{1'b0, 2'd3, 8'h00, 8'h5A, 1'b1};
    vecs[4] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 2'd0, 8'h81, 8'h00, 1'b0};

    repeat (3) @(negedge CLK);
    chk("reset NCS", 32'(NCS), 1);
    chk("reset NO", 32'(NO), 1);
    chk("reset NW", 32'(NW), 1);
    chk("reset ADDR", 32'(ADDR), 0);
    chk("reset DATA hiz", 32'(DATA === 8'hzz), 1);
    chk("reset cmd_ready", 32'(bif.cmd_ready), 0);
    chk("reset rsp_valid", 32'(bif.rsp_valid), 0);
    chk("reset rsp_rdata", 32'(bif.rsp_rdata), 0);
    chk("reset rx_valid", 32'(rx_valid), 0);
    chk("reset rx_data", 32'(rx_data), 0);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle cmd_ready", 32'(bif.cmd_ready), 1);

    for (int i = 0; i < 6; i++) begin
      acc_q.delete();
      preg[vecs[i].a] = vecs[i].rd;
      bif.cmd_valid = 1'b1;
      bif.cmd_write = vecs[i].w;
      bif.cmd_addr  = vecs[i].a;
      bif.cmd_wdata = vecs[i].wd;
      wait_ready($sformatf("v%0d", i));
      @(negedge CLK);
      bif.cmd_valid = 1'b0;
      bif.cmd_write = ~vecs[i].w;
      bif.cmd_addr  = ~vecs[i].a;
      bif.cmd_wdata = ~vecs[i].wd;
      rsp_n = 0;
      rsp_at = -1;
      rx_n = 0;
      for (int k = 0; k < W + 4; k++) begin
        if (k > 0) @(negedge CLK);
        if (bif.rsp_valid) begin
          rsp_n++;
          rsp_at = k;
        end
        if (rx_valid) rx_n++;
      end
      chk($sformatf("v%0d rsp count", i), rsp_n, 32'(vecs[i].rsp));
      chk($sformatf("v%0d rsp cycle", i), rsp_at,
          vecs[i].rsp ? W + 2 : -1);
      if (!vecs[i].w)
        chk($sformatf("v%0d rdata", i), 32'(bif.rsp_rdata),
            32'(vecs[i].rd));
      chk($sformatf("v%0d rx none", i), rx_n, 0);
      chk($sformatf("v%0d accesses", i), acc_q.size(), 1);
      if (acc_q.size() > 0) begin
        chk($sformatf("v%0d addr", i), 32'(acc_q[0].addr),
            32'(vecs[i].a));
        chk($sformatf("v%0d NW low", i), acc_q[0].nwlow,
            vecs[i].w ? W : 0);
        chk($sformatf("v%0d NO low", i), acc_q[0].nolow,
            vecs[i].w ? 0 : W);
        chk($sformatf("v%0d NCS low", i), acc_q[0].ncyc, W + 2);
        chk($sformatf("v%0d bus ok", i), 32'(acc_q[0].ok), 1);
        chk($sformatf("v%0d setup hiz", i), 32'(acc_q[0].sz),
            32'(!vecs[i].w));
        if (vecs[i].w)
          chk($sformatf("v%0d wdata", i), 32'(acc_q[0].sdata),
              32'(vecs[i].wd));
      end
    end

    // Interrupt with data; irq_en dropped once service has begun.
    acc_q.delete();
    preg[0] = 8'h02;
    preg[2] = 8'h41;
    irq_en = 1'b1;
    NINT = 1'b0;
    lat = 0;
    while (NCS !== 1'b0 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    chk("irq latency", 32'(lat >= 1 && lat <= 3), 1);
    NINT = 1'b1;
    irq_en = 1'b0;
    rdy_n = 0;
    rsp_n = 0;
    n = 0;
    while (rx_valid !== 1'b1 && n < 40) begin
      if (bif.cmd_ready) rdy_n++;
      if (bif.rsp_valid) rsp_n++;
      @(negedge CLK);
      n++;
    end
    chk("irq rx_valid", 32'(rx_valid), 1);
    chk("irq rx_data", 32'(rx_data), 32'h41);
    chk("irq cmd_ready low", rdy_n, 0);
    chk("irq no rsp", rsp_n, 0);
    @(negedge CLK);
    chk("irq rx pulse", 32'(rx_valid), 0);
    chk("irq accesses", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("irq stat addr", 32'(acc_q[0].addr), 0);
      chk("irq stat read", acc_q[0].nolow, W);
      chk("irq stat nowrite", acc_q[0].nwlow, 0);
      chk("irq data addr", 32'(acc_q[1].addr), 2);
      chk("irq data read", acc_q[1].nolow, W);
      chk("irq data gap", acc_q[1].gap, 1);
      chk("irq bus ok", 32'(acc_q[0].ok && acc_q[1].ok), 1);
    end

    // Empty status: a single status read.
    acc_q.delete();
    preg[0] = 8'h00;
    irq_en = 1'b1;
    NINT = 1'b0;
    wait_ncs(1'b0, "empty start");
    NINT = 1'b1;
    rx_n = 0;
    repeat (12) begin
      @(negedge CLK);
      if (rx_valid) rx_n++;
    end
    chk("empty accesses", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("empty addr", 32'(acc_q[0].addr), 0);
    chk("empty no rx", rx_n, 0);

    // Level NINT re-triggers service straight after the first one.
    acc_q.delete();
    NINT = 1'b0;
    wait_ncs(1'b0, "resvc first");
    wait_ncs(1'b1, "resvc end");
    wait_ncs(1'b0, "resvc second");
    NINT = 1'b1;
    rx_n = 0;
    repeat (12) begin
      @(negedge CLK);
      if (rx_valid) rx_n++;
    end
    chk("resvc accesses", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("resvc addr", 32'(acc_q[1].addr), 0);
      chk("resvc gap", acc_q[1].gap, 1);
    end
    chk("resvc no rx", rx_n, 0);

    // Service and command pending together: service wins.
    acc_q.delete();
    preg[1] = 8'hC3;
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 2'd2;
    bif.cmd_wdata = 8'h11;
    wait_ready("sim write");
    @(negedge CLK);
    NINT = 1'b0;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 2'd1;
    wait_ncs(1'b1, "sim write end");
    wait_ncs(1'b0, "sim svc start");
    NINT = 1'b1;
    wait_ready("sim read");
    @(negedge CLK);
    bif.cmd_valid = 1'b0;
    rsp_n = 0;
    repeat (W + 3) begin
      @(negedge CLK);
      if (bif.rsp_valid) rsp_n++;
    end
    chk("sim rsp count", rsp_n, 1);
    chk("sim rdata", 32'(bif.rsp_rdata), 32'hC3);
    chk("sim accesses", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("sim first write", 32'(acc_q[0].w), 1);
      chk("sim first wdata", 32'(acc_q[0].sdata), 32'h11);
      chk("sim svc addr", 32'(acc_q[1].addr), 0);
      chk("sim svc gap", acc_q[1].gap, 1);
      chk("sim host addr", 32'(acc_q[2].addr), 1);
      chk("sim host gap", acc_q[2].gap, 1);
    end

    // Back-to-back host writes.
    irq_en = 1'b0;
    acc_q.delete();
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 2'd2;
    bif.cmd_wdata = 8'h11;
    wait_ready("b2b first");
    @(negedge CLK);
    bif.cmd_addr  = 2'd3;
    bif.cmd_wdata = 8'h22;
    wait_ready("b2b second");
    @(negedge CLK);
    bif.cmd_valid = 1'b0;
    repeat (W + 3) @(negedge CLK);
    chk("b2b accesses", acc_q.size(), 2);
    if (acc_q.size() == 2) begin
      chk("b2b first wdata", 32'(acc_q[0].sdata), 32'h11);
      chk("b2b gap", acc_q[1].gap, 1);
      chk("b2b second addr", 32'(acc_q[1].addr), 3);
      chk("b2b second wdata", 32'(acc_q[1].sdata), 32'h22);
    end

    // Reset in the middle of a write strobe.
    acc_q.delete();
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b1;
    bif.cmd_addr  = 2'd3;
    bif.cmd_wdata = 8'h99;
    wait_ready("rst write");
    @(negedge CLK);
    bif.cmd_valid = 1'b0;
    @(negedge CLK);
    chk("rst pre NW", 32'(NW), 0);
    #2 RST = 1'b1;
    #1;
    chk("rst NW", 32'(NW), 1);
    chk("rst NCS", 32'(NCS), 1);
    chk("rst NO", 32'(NO), 1);
    chk("rst DATA hiz", 32'(DATA === 8'hzz), 1);
    chk("rst cmd_ready", 32'(bif.cmd_ready), 0);
    @(negedge CLK);
    #1 RST = 1'b0;
    rsp_n = 0;
    rx_n = 0;
    repeat (6) begin
      @(negedge CLK);
      if (bif.rsp_valid) rsp_n++;
      if (rx_valid) rx_n++;
    end
    chk("rst no rsp", rsp_n + rx_n, 0);
    chk("rst idle ready", 32'(bif.cmd_ready), 1);
    preg[1] = 8'h3C;
    bif.cmd_valid = 1'b1;
    bif.cmd_write = 1'b0;
    bif.cmd_addr  = 2'd1;
    wait_ready("post rst read");
    @(negedge CLK);
    bif.cmd_valid = 1'b0;
    rsp_at = -1;
    for (int k = 0; k < W + 4; k++) begin
      if (k > 0) @(negedge CLK);
      if (bif.rsp_valid) rsp_at = k;
    end
    chk("post rst rsp cycle", rsp_at, W + 2);
    chk("post rst rdata", 32'(bif.rsp_rdata), 32'h3C);
    chk("post rst accesses", acc_q.size(), 1);
    if (acc_q.size() > 0) chk("post rst addr", 32'(acc_q[0].addr), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
